// File: rtl/genius_pkg.sv
// Shared key codes, FSM encodings and default timing for the Genius key reader.
package genius_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        RED    = 2'd1,
        YELLOW = 2'd2,
        BLUE   = 2'd3
    } key_code_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_PRESS,
        S_WAIT_REL,
        S_DONE
    } state_e;

    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int DEF_TIMEOUT_CYC  = 250_000_000;
    localparam int DEF_AW           = 4;

    // Lowest pressed index wins; only meaningful as a colour when one key is down.
    function automatic logic [1:0] key_enc(input logic [3:0] k);
        key_enc = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (k[i]) key_enc = 2'(i);
        end
    endfunction

endpackage

// File: rtl/genius_key_reader_debouncer.sv
// One pushbutton: 2-FF synchroniser plus stable-level counter.
module key_debouncer
    import genius_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clock,
    input  logic reset_i,
    input  logic key_n_i,
    output logic pressed_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (!reset_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pressed_o = ~level_q;

endmodule

// File: rtl/genius_key_reader.sv
// Genius player-reply reader: debounced KEY presses checked against the stored sequence.
// Optional GENIUS_KEY_ECHO_EN adds led_echo_o with the debounced pressed keys.
module genius_key_reader
    import genius_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int AW           = DEF_AW
) (
    input  logic          clock,
    input  logic          reset_i,
    input  logic [3:0]    KEY_i,
    input  logic          start_i,
    input  logic [AW:0]   len_i,
    input  logic [1:0]    exp_code_i,
    output logic [AW-1:0] rd_addr_o,
    output logic [1:0]    key_code_o,
    output logic          match_o,
    output logic          miss_o,
    output logic          end_User_o,
    output logic          end_time_o,
    output logic          busy_o
`ifdef GENIUS_KEY_ECHO_EN
    ,
    output logic [3:0]    led_echo_o
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [3:0]    pressed;
    logic [3:0]    prev_q;
    state_e        state_q;
    logic [AW:0]   len_q;
    logic [AW:0]   cnt_q;
    logic [TW-1:0] timer_q;
    logic [1:0]    key_code_q;
    logic          match_q;
    logic          miss_q;
    logic          end_user_q;
    logic          end_time_q;

    for (genvar g = 0; g < 4; g++) begin : g_db
        key_debouncer #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .clock    (clock),
            .reset_i  (reset_i),
            .key_n_i  (KEY_i[g]),
            .pressed_o(pressed[g])
        );
    end

    logic       press_ev;
    logic [1:0] code_d;
    logic       good_d;

    // A press is only the all-released -> any-pressed transition.
    assign press_ev = ~|prev_q & |pressed;
    assign code_d   = key_enc(pressed);
    assign good_d   = $onehot(pressed) && (code_d == exp_code_i);

    always_ff @(posedge clock) begin
        if (!reset_i) begin
            state_q    <= S_IDLE;
            prev_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            key_code_q <= '0;
            match_q    <= 1'b0;
            miss_q     <= 1'b0;
            end_user_q <= 1'b0;
            end_time_q <= 1'b0;
        end else begin
            prev_q  <= pressed;
            match_q <= 1'b0;
            miss_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        len_q      <= len_i;
                        cnt_q      <= '0;
                        timer_q    <= '0;
                        end_time_q <= 1'b0;
                        if (len_i == '0) begin
                            end_user_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            end_user_q <= 1'b0;
                            state_q    <= S_WAIT_PRESS;
                        end
                    end
                end
                S_WAIT_PRESS: begin
                    if (press_ev) begin
                        key_code_q <= code_d;
                        if (good_d) begin
                            match_q <= 1'b1;
                            cnt_q   <= cnt_q + 1'b1;
                            timer_q <= '0;
                            state_q <= S_WAIT_REL;
                        end else begin
                            miss_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        end_time_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_WAIT_REL: begin
                    if (pressed == '0) begin
                        timer_q <= '0;
                        if (cnt_q == len_q) begin
                            end_user_q <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            state_q <= S_WAIT_PRESS;
                        end
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_addr_o  = cnt_q[AW-1:0];
    assign key_code_o = key_code_q;
    assign match_o    = match_q;
    assign miss_o     = miss_q;
    assign end_User_o = end_user_q;
    assign end_time_o = end_time_q;
    assign busy_o     = (state_q != S_IDLE);
`ifdef GENIUS_KEY_ECHO_EN
    assign led_echo_o = pressed;
`endif

endmodule

// File: tb/tb_genius_key_reader.sv
// Directed bench for genius_key_reader with short debounce/timeout values.
module tb_genius_key_reader;

    localparam int D  = 4;
    localparam int TO = 100;
    localparam int AW = 2;

    logic          clock = 1'b0;
    logic          reset_i = 1'b0;
    logic [3:0]    KEY_i = 4'hF;
    logic          start_i = 1'b0;
    logic [AW:0]   len_i = '0;
    logic [1:0]    exp_code;
    logic [AW-1:0] rd_addr;
    logic [1:0]    key_code;
    logic          match_o, miss_o, end_user, end_time, busy;
`ifdef GENIUS_KEY_ECHO_EN
    logic [3:0]    led_echo;
`endif

    logic [1:0] seq [4];
    assign exp_code = seq[rd_addr];

    genius_key_reader #(
        .DEBOUNCE_CYC(D),
        .TIMEOUT_CYC (TO),
        .AW          (AW)
    ) dut (
        .clock     (clock),
        .reset_i   (reset_i),
        .KEY_i     (KEY_i),
        .start_i   (start_i),
        .len_i     (len_i),
        .exp_code_i(exp_code),
        .rd_addr_o (rd_addr),
        .key_code_o(key_code),
        .match_o   (match_o),
        .miss_o    (miss_o),
        .end_User_o(end_user),
        .end_time_o(end_time),
        .busy_o    (busy)
`ifdef GENIUS_KEY_ECHO_EN
        ,
        .led_echo_o(led_echo)
`endif
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_match = 0;
    int n_miss = 0;
    int match_cyc = 0;
    always @(negedge clock) begin
        if (match_o) begin
            n_match++;
            match_cyc = cyc;
        end
        if (miss_o) n_miss++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input logic [AW:0] l);
        len_i   = l;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic press(input logic [3:0] k);
        KEY_i = ~k;
        repeat (10) tick();
        KEY_i = 4'hF;
        repeat (12) tick();
    endtask

    typedef struct {
        logic [AW:0] len;
        logic [1:0]  e0;
        logic [3:0]  keys;
        int          m;
        int          x;
        bit          chk_code;
        logic [1:0]  code;
        logic        eu;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int bm, bx, sc;

        tbl[0] = '{len: 1, e0: 0, keys: 4'b0001, m: 1, x: 0, chk_code: 1, code: 0, eu: 1};
        tbl[1] = '{len: 1, e0: 3, keys: 4'b1000, m: 1, x: 0, chk_code: 1, code: 3, eu: 1};
        tbl[2] = '{len: 1, e0: 2, keys: 4'b0010, m: 0, x: 1, chk_code: 1, code: 1, eu: 0};
        tbl[3] = '{len: 1, e0: 0, keys: 4'b1001, m: 0, x: 1, chk_code: 0, code: 0, eu: 0};
        tbl[4] = '{len: 1, e0: 1, keys: 4'b0010, m: 1, x: 0, chk_code: 1, code: 1, eu: 1};
        for (int i = 0; i < 4; i++) seq[i] = 2'd0;

        repeat (3) tick();
        chk("reset busy", busy, 0);
        chk("reset rd_addr", rd_addr, 0);
        chk("reset key_code", key_code, 0);
        chk("reset end_user", end_user, 0);
        chk("reset end_time", end_time, 0);
        chk("reset pulses", match_o | miss_o, 0);
        reset_i = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < 5; i++) begin
            bm = n_match;
            bx = n_miss;
            seq[0] = tbl[i].e0;
            start(tbl[i].len);
            press(tbl[i].keys);
            chk($sformatf("vec%0d match", i), n_match - bm, tbl[i].m);
            chk($sformatf("vec%0d miss", i), n_miss - bx, tbl[i].x);
            if (tbl[i].chk_code) chk($sformatf("vec%0d code", i), key_code, tbl[i].code);
            chk($sformatf("vec%0d end_user", i), end_user, tbl[i].eu);
            chk($sformatf("vec%0d busy", i), busy, 0);
        end

        // Three-press correct reply
        bm = n_match;
        seq[0] = 2; seq[1] = 0; seq[2] = 3;
        start(3);
        chk("t1 rd_addr0", rd_addr, 0);
        press(4'b0100);
        chk("t1 rd_addr1", rd_addr, 1);
        press(4'b0001);
        chk("t1 rd_addr2", rd_addr, 2);
        press(4'b1000);
        chk("t1 rd_addr3", rd_addr, 3);
        chk("t1 matches", n_match - bm, 3);
        chk("t1 end_user", end_user, 1);

        // Correct then wrong press
        bm = n_match; bx = n_miss;
        seq[0] = 1; seq[1] = 1;
        start(2);
        chk("t2 end_user cleared", end_user, 0);
        press(4'b0010);
        press(4'b0100);
        chk("t2 matches", n_match - bm, 1);
        chk("t2 misses", n_miss - bx, 1);
        chk("t2 key_code", key_code, 2);
        chk("t2 end_user", end_user, 0);

        // Bouncing KEY1, then stable
        bm = n_match;
        seq[0] = 1;
        start(1);
        for (int g = 0; g < 5; g++) begin
            KEY_i = 4'b1101;
            repeat (3) tick();
            KEY_i = 4'hF;
            tick();
        end
        KEY_i = 4'b1101;
        sc = cyc;
        repeat (10) tick();
        chk("t3 one press", n_match - bm, 1);
        chk("t3 latency", match_cyc - sc, 7);
        KEY_i = 4'hF;
        repeat (12) tick();
        chk("t3 end_user", end_user, 1);

        // Timeout
        bm = n_match; bx = n_miss;
        seq[0] = 0;
        start(1);
        repeat (TO - 1) tick();
        chk("t4 end_time early", end_time, 0);
        chk("t4 busy early", busy, 1);
        tick();
        chk("t4 end_time", end_time, 1);
        chk("t4 busy", busy, 0);
        press(4'b0001);
        chk("t4 no pulses", (n_match - bm) + (n_miss - bx), 0);
        chk("t4 end_time held", end_time, 1);

        // Reset mid-reply
        seq[0] = 1; seq[1] = 2; seq[2] = 3;
        start(3);
        press(4'b0010);
        KEY_i = 4'b1011;
        repeat (10) tick();
        chk("t5 rd_addr pre-reset", rd_addr, 2);
        reset_i = 1'b0;
        KEY_i = 4'hF;
        tick();
        chk("t5 rst busy", busy, 0);
        chk("t5 rst rd_addr", rd_addr, 0);
        chk("t5 rst key_code", key_code, 0);
        chk("t5 rst ends", {end_user, end_time}, 0);
        reset_i = 1'b1;
        repeat (12) tick();
        bm = n_match;
        seq[0] = 3;
        start(1);
        press(4'b1000);
        chk("t5 restart match", n_match - bm, 1);
        chk("t5 restart end_user", end_user, 1);

        // Zero length and full-length wrap
        start(0);
        chk("t6 len0 end_user", end_user, 1);
        chk("t6 len0 busy", busy, 1);
        tick();
        chk("t6 len0 idle", busy, 0);
        chk("t6 len0 end_user held", end_user, 1);
        bm = n_match;
        seq[0] = 0; seq[1] = 1; seq[2] = 2; seq[3] = 3;
        start(4);
        press(4'b0001);
        press(4'b0010);
        press(4'b0100);
        chk("t6 rd_addr3", rd_addr, 3);
        press(4'b1000);
        chk("t6 wrap", rd_addr, 0);
        chk("t6 matches", n_match - bm, 4);
        chk("t6 end_user", end_user, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
